// File: rtl/llr_framer_a20.sv
// LLR scaler/saturator and codeword framer in front of the (20,A) block decoder.
// Optional macro SAT_COUNT_EN adds a saturating count of clipped input symbols.
module llr_framer_a20 #(
   parameter int unsigned IN_WIDTH    = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned NUM_SYMBOLS = 20
) (
   input  logic                  clk,
   input  logic                  s_axis_areset,
   input  logic [3:0]            shift,
   input  logic                  shift_valid,
   input  logic [IN_WIDTH-1:0]   s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  short_frame,
   output logic                  long_frame
`ifdef SAT_COUNT_EN
   ,
   output logic [15:0]           sat_count
`endif
);

   localparam int unsigned CNT_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
   localparam int unsigned EXT_W = IN_WIDTH + 1;
   localparam int unsigned ENT_W = DATA_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SYMBOLS - 1);
   localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_LO = -SAT_HI;

   localparam logic [0:0] ST_RUN = 1'b0;
   localparam logic [0:0] ST_PAD = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [3:0]       shift_pend_q, shift_pend_d;
   logic [3:0]       shift_act_q, shift_act_d;
   logic             head_v_q, head_v_d;
   logic             sec_v_q, sec_v_d;
   logic [ENT_W-1:0] head_q, head_d;
   logic [ENT_W-1:0] sec_q, sec_d;
   logic             tready_q, tready_d;
   logic             short_q, short_d;
   logic             long_q, long_d;

   logic                    in_acc;
   logic                    pad_wr;
   logic                    wr;
   logic [ENT_W-1:0]        wr_ent;
   logic [3:0]              shift_use;
   logic signed [EXT_W-1:0] x_ext;
   logic signed [EXT_W-1:0] rnd;
   logic signed [EXT_W-1:0] scaled;
   logic [DATA_WIDTH-1:0]   sym_in;
   logic                    clipped;

   // Round-half-up scaling and symmetric saturation of the incoming LLR.
   // The index-0 symbol already uses the pending shift it latches.
   always_comb begin
      shift_use = (sym_cnt_q == '0) ? shift_pend_q : shift_act_q;
      x_ext     = {s_axis_tdata[IN_WIDTH-1], s_axis_tdata};
      rnd       = '0;
      if (shift_use != 4'd0) begin
         rnd = EXT_W'(1) << (shift_use - 4'd1);
      end
      scaled  = (x_ext + rnd) >>> shift_use;
      sym_in  = scaled[DATA_WIDTH-1:0];
      clipped = 1'b0;
      if (scaled > SAT_HI) begin
         sym_in  = SAT_HI[DATA_WIDTH-1:0];
         clipped = 1'b1;
      end else if (scaled < SAT_LO) begin
         sym_in  = SAT_LO[DATA_WIDTH-1:0];
         clipped = 1'b1;
      end
   end

   // Framing FSM, symbol counter and 2-entry skid buffer.
   always_comb begin
      state_d      = state_q;
      sym_cnt_d    = sym_cnt_q;
      shift_pend_d = shift_pend_q;
      shift_act_d  = shift_act_q;
      head_v_d     = head_v_q;
      sec_v_d      = sec_v_q;
      head_d       = head_q;
      sec_d        = sec_q;
      short_d      = 1'b0;
      long_d       = 1'b0;

      in_acc = s_axis_tvalid && tready_q;
      pad_wr = (state_q == ST_PAD) && !(head_v_q && sec_v_q && !m_axis_tready);
      wr     = in_acc || pad_wr;
      wr_ent = {(sym_cnt_q == LAST_IDX), (pad_wr ? '0 : sym_in)};

      if (shift_valid) begin
         shift_pend_d = shift;
      end
      if (in_acc && (sym_cnt_q == '0)) begin
         shift_act_d = shift_pend_q;
      end

      if (wr) begin
         sym_cnt_d = (sym_cnt_q == LAST_IDX) ? '0 : sym_cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_RUN: begin
            if (in_acc && s_axis_tlast && (sym_cnt_q != LAST_IDX)) begin
               short_d = 1'b1;
               state_d = ST_PAD;
            end
            if (in_acc && !s_axis_tlast && (sym_cnt_q == LAST_IDX)) begin
               long_d = 1'b1;
            end
         end
         ST_PAD: begin
            if (pad_wr && (sym_cnt_q == LAST_IDX)) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Head drives the outputs; the second entry absorbs one stalled write.
      if (!head_v_q || m_axis_tready) begin
         if (sec_v_q) begin
            head_v_d = 1'b1;
            head_d   = sec_q;
            sec_v_d  = wr;
            if (wr) begin
               sec_d = wr_ent;
            end
         end else begin
            head_v_d = wr;
            if (wr) begin
               head_d = wr_ent;
            end
         end
      end else if (wr) begin
         sec_v_d = 1'b1;
         sec_d   = wr_ent;
      end

      tready_d = (state_d == ST_RUN) && !(head_v_d && sec_v_d);
   end

   always_ff @(posedge clk) begin
      if (s_axis_areset) begin
         state_q      <= ST_RUN;
         sym_cnt_q    <= '0;
         shift_pend_q <= '0;
         shift_act_q  <= '0;
         head_v_q     <= 1'b0;
         sec_v_q      <= 1'b0;
         head_q       <= '0;
         sec_q        <= '0;
         tready_q     <= 1'b0;
         short_q      <= 1'b0;
         long_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sym_cnt_q    <= sym_cnt_d;
         shift_pend_q <= shift_pend_d;
         shift_act_q  <= shift_act_d;
         head_v_q     <= head_v_d;
         sec_v_q      <= sec_v_d;
         head_q       <= head_d;
         sec_q        <= sec_d;
         tready_q     <= tready_d;
         short_q      <= short_d;
         long_q       <= long_d;
      end
   end

`ifdef SAT_COUNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Sticky-at-max count of clipped accepted symbols; shift_valid restarts it.
   always_comb begin
      sat_cnt_d = sat_cnt_q;
      if (shift_valid) begin
         sat_cnt_d = '0;
      end else if (in_acc && clipped && (sat_cnt_q != 16'hFFFF)) begin
         sat_cnt_d = sat_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (s_axis_areset) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   assign sat_count = sat_cnt_q;
`endif

   assign s_axis_tready = tready_q;
   assign m_axis_tvalid = head_v_q;
   assign m_axis_tdata  = head_q[DATA_WIDTH-1:0];
   assign m_axis_tlast  = head_q[DATA_WIDTH];
   assign short_frame   = short_q;
   assign long_frame    = long_q;

endmodule

// File: tb/tb_llr_framer_a20.sv
// Randomized bench for llr_framer_a20 against a queue-based codeword model.
module tb_llr_framer_a20;

   localparam int NS = 20;

   logic        clk = 1'b0;
   logic        s_axis_areset = 1'b1;
   logic [3:0]  shift = 4'd0;
   logic        shift_valid = 1'b0;
   logic [15:0] s_axis_tdata = 16'd0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        short_frame;
   logic        long_frame;
`ifdef SAT_COUNT_EN
   logic [15:0] sat_count;
`endif

   always #5 clk = ~clk;

   llr_framer_a20 dut (
      .clk           (clk),
      .s_axis_areset (s_axis_areset),
      .shift         (shift),
      .shift_valid   (shift_valid),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .short_frame   (short_frame),
      .long_frame    (long_frame)
`ifdef SAT_COUNT_EN
      ,
      .sat_count     (sat_count)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Reference: round half up by floor division, then clip to +/-127.
   function automatic int ref_scale(input int x, input int s);
      int d, num, y;
      if (s == 0) begin
         y = x;
      end else begin
         d   = 1 << s;
         num = x + d / 2;
         y   = (num >= 0) ? num / d : -((-num + d - 1) / d);
      end
      return y;
   endfunction

   function automatic int ref_clip(input int y);
      if (y > 127) return 127;
      if (y < -127) return -127;
      return y;
   endfunction

   // Expected output stream; pad entries are tagged so the ready rule can be skipped while padding.
   int exp_d[$];
   bit exp_l[$];
   bit exp_p[$];
   int npad = 0;
   int idx = 0;
   int pend = 0;
   int act = 0;
   int satc = 0;
   bit exp_short = 0, exp_long = 0;
   bit rst_prev = 1'b1;
   bit acc_prev = 0;
   bit hold_v = 0;
   int hold_d = 0;
   bit hold_l = 0;
   int mode = 0;
   int phase = 0;

   always @(negedge clk) begin
      int x, s, y;
      bit in_acc;
      if (rst_prev) begin
         chk("rst_m_tvalid", m_axis_tvalid, 0);
         chk("rst_s_tready", s_axis_tready, 0);
         chk("rst_m_tdata", int'(m_axis_tdata), 0);
         chk("rst_m_tlast", m_axis_tlast, 0);
         chk("rst_pulses", {short_frame, long_frame}, 0);
      end else begin
         chk("short_frame", short_frame, exp_short);
         chk("long_frame", long_frame, exp_long);
         if (acc_prev) chk("latency", m_axis_tvalid, 1);
         if (hold_v) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_data", int'($signed(m_axis_tdata)), hold_d);
            chk("hold_last", m_axis_tlast, hold_l);
         end
         if (npad == 0) chk("s_tready_rule", s_axis_tready, int'(exp_d.size() < 2));
`ifdef SAT_COUNT_EN
         chk("sat_count", int'(sat_count), satc);
`endif
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_d.size() == 0) begin
               chk("spurious_out", 1, 0);
            end else begin
               chk("out_data", int'($signed(m_axis_tdata)), exp_d[0]);
               chk("out_last", m_axis_tlast, exp_l[0]);
               if (exp_p[0]) npad--;
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
               void'(exp_p.pop_front());
            end
         end
      end

      if (s_axis_areset) begin
         exp_d.delete(); exp_l.delete(); exp_p.delete();
         npad = 0; idx = 0; pend = 0; act = 0; satc = 0;
         exp_short = 0; exp_long = 0; hold_v = 0; acc_prev = 0;
      end else begin
         in_acc = s_axis_tvalid && s_axis_tready;
         exp_short = 0;
         exp_long  = 0;
         if (in_acc) begin
            x = int'($signed(s_axis_tdata));
            s = (idx == 0) ? pend : act;
            if (idx == 0) act = pend;
            y = ref_scale(x, s);
            if (ref_clip(y) != y && satc < 65535) satc++;
            exp_d.push_back(ref_clip(y));
            exp_l.push_back(idx == NS - 1);
            exp_p.push_back(1'b0);
            if (s_axis_tlast && idx < NS - 1) begin
               exp_short = 1;
               for (int k = idx + 1; k < NS; k++) begin
                  exp_d.push_back(0);
                  exp_l.push_back(k == NS - 1);
                  exp_p.push_back(1'b1);
                  npad++;
               end
               idx = 0;
            end else if (idx == NS - 1) begin
               exp_long = !s_axis_tlast;
               idx = 0;
            end else begin
               idx++;
            end
         end
         if (shift_valid) begin
            pend = int'(shift);
            satc = 0;
         end
         hold_v   = m_axis_tvalid && !m_axis_tready;
         hold_d   = int'($signed(m_axis_tdata));
         hold_l   = m_axis_tlast;
         acc_prev = in_acc;
      end
      rst_prev = s_axis_areset;
   end

   // Downstream ready: always on, random, or 20 low / 10 high.
   always @(posedge clk) begin
      #1;
      case (mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = ($urandom_range(0, 3) != 0);
         default: begin
            m_axis_tready = ((phase % 30) >= 20);
            phase++;
         end
      endcase
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int data, input bit last, input bit sv = 1'b0, input int sv_val = 0);
      int n = 0;
      s_axis_tdata  = 16'(data);
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      if (sv) begin
         shift       = 4'(sv_val);
         shift_valid = 1'b1;
      end
      forever begin
         @(negedge clk);
         if (s_axis_tready) break;
         n++;
         if (n > 3000) begin
            chk("send_timeout", 0, 1);
            finish_run();
         end
      end
      @(posedge clk);
      #1;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      shift_valid   = 1'b0;
   endtask

   task automatic set_shift(input int v);
      shift       = 4'(v);
      shift_valid = 1'b1;
      idle(1);
      shift_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      s_axis_areset = 1'b1;
      idle(n);
      s_axis_areset = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_d.size() != 0 && n < 3000) begin
         idle(1);
         n++;
      end
      chk("drain_empty", exp_d.size(), 0);
   endtask

   function automatic int rnd_llr();
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 0) return $urandom_range(0, 600) - 300;
      return int'($signed(r));
   endfunction

   initial begin
      int len;
      int b0[6];
      do_reset(3);
      idle(2);

      for (int i = 0; i < NS; i++) send(i, i == NS - 1);
      drain();

      set_shift(2);
      b0 = '{10, -10, 6, 1000, -1000, 0};
      for (int i = 0; i < NS; i++) send((i < 5) ? b0[i] : rnd_llr(), i == NS - 1);
      drain();

      for (int i = 0; i < 13; i++) send(rnd_llr(), i == 12);
      drain();

      for (int i = 0; i < 25; i++) send(rnd_llr(), 1'b0);
      send(rnd_llr(), 1'b1);
      drain();

      mode = 2;
      for (int f = 0; f < 13; f++)
         for (int i = 0; i < NS; i++) send(rnd_llr(), i == NS - 1);
      drain();
      mode = 0;

      for (int i = 0; i < NS; i++) send(rnd_llr(), i == NS - 1, i == 5, 3);
      for (int i = 0; i < NS; i++) send(rnd_llr(), i == NS - 1);
      drain();
      for (int i = 0; i < 8; i++) send(rnd_llr(), 1'b0);
      do_reset(2);
      idle(1);
      for (int i = 0; i < NS; i++) send(rnd_llr(), i == NS - 1);
      drain();

      set_shift(0);
      b0 = '{127, 128, -127, -128, -32768, 32767};
      for (int i = 0; i < NS; i++) send((i < 6) ? b0[i] : rnd_llr(), i == NS - 1);
      set_shift(15);
      b0 = '{32767, -32768, 16384, 16383, -16384, -16385};
      for (int i = 0; i < NS; i++) send((i < 6) ? b0[i] : rnd_llr(), i == NS - 1);
      drain();

      mode = 1;
      for (int f = 0; f < 40; f++) begin
         len = $urandom_range(1, 45);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(rnd_llr(), i == len - 1, $urandom_range(0, 29) == 0, $urandom_range(0, 15));
         end
      end
      drain();
      mode = 0;
      idle(3);
      finish_run();
   end

endmodule
